branch_resolve_bht: RTL and testbench

//  Execute-stage branch/jump resolution unit with a parametrised 2-bit saturating-counter branch

---
 rtl/branch_resolve_bht.sv | 141 ++++++++++++++
 tb/tb_branch_resolve_bht.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - execute-stage branch/jump resolution with 2-bit BHT and perf counters
module branch_resolve_bht #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 16,
  parameter logic [1:0] INIT_STATE  = 2'b01,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_f,
  output logic             pred_taken_f,
  input  logic             valid_e,
  input  logic             stall_e,
  input  logic [XLEN-1:0]  pc_e,
  input  logic             branch_e,
  input  logic             jump_e,
  input  logic             jalr_e,
  input  logic [2:0]       funct3_e,
  input  logic             Zero_e,
  input  logic             Lt_e,
  input  logic             Ltu_e,
  input  logic             pred_taken_e,
  output logic [1:0]       PCSrc_e,
  output logic             flush_e,
  output logic             illegal_br_e,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic             act;
  logic             taken;
  logic             bad_funct3;
  logic             upd;
  logic             mispred;
  logic [1:0]       cur_cnt;

  // PC bits outside the index field do not influence the predictor
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0], pc_e[XLEN-1:IDX_W+2], pc_e[1:0]};

  assign idx_f = pc_f[IDX_W+1:2];
  assign idx_e = pc_e[IDX_W+1:2];

  // Fetch-side prediction: direct read of the stored counter, so a same-cycle write is not seen
  always_comb begin
    pred_taken_f = bht_q[idx_f][1];
  end

  // Branch condition decode and resolution priority (JALR > JAL > illegal > legal branch)
  always_comb begin
    act          = valid_e & ~stall_e;
    taken        = 1'b0;
    bad_funct3   = (funct3_e == 3'b010) || (funct3_e == 3'b011);
    upd          = 1'b0;
    mispred      = 1'b0;
    PCSrc_e      = 2'b00;
    flush_e      = 1'b0;
    illegal_br_e = 1'b0;

    case (funct3_e)
      3'b000:  taken = Zero_e;
      3'b001:  taken = ~Zero_e;
      3'b100:  taken = Lt_e;
      3'b101:  taken = ~Lt_e;
      3'b110:  taken = Ltu_e;
      3'b111:  taken = ~Ltu_e;
      default: taken = 1'b0;
    endcase

    if (act) begin
      if (jalr_e) begin
        PCSrc_e = 2'b10;
        flush_e = 1'b1;
      end else if (jump_e) begin
        PCSrc_e = 2'b01;
        flush_e = 1'b1;
      end else if (branch_e) begin
        if (bad_funct3) begin
          illegal_br_e = 1'b1;
        end else begin
          upd     = 1'b1;
          mispred = (taken != pred_taken_e);
          if (mispred) begin
            flush_e = 1'b1;
            PCSrc_e = taken ? 2'b01 : 2'b11;
          end
        end
      end
    end
  end

  // Next-state: saturating BHT counter step and saturating performance counters
  always_comb begin
    bht_d           = bht_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    cur_cnt         = bht_q[idx_e];

    if (upd) begin
      if (taken) begin
        bht_d[idx_e] = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'b01;
      end else begin
        bht_d[idx_e] = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'b01;
      end
      if (!(&br_count_q)) begin
        br_count_d = br_count_q + CNT_W'(1);
      end
      if (mispred && !(&mispred_count_q)) begin
        mispred_count_d = mispred_count_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset is asynchronous so it takes effect without a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= INIT_STATE;
      end
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      bht_q           <= bht_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - scoreboard bench for branch_resolve_bht with a behavioural model
module tb_branch_resolve_bht;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [XLEN-1:0]  pc_f = '0;
  logic             pred_taken_f;
  logic             valid_e = 1'b0;
  logic             stall_e = 1'b0;
  logic [XLEN-1:0]  pc_e = '0;
  logic             branch_e = 1'b0;
  logic             jump_e = 1'b0;
  logic             jalr_e = 1'b0;
  logic [2:0]       funct3_e = '0;
  logic             Zero_e = 1'b0;
  logic             Lt_e = 1'b0;
  logic             Ltu_e = 1'b0;
  logic             pred_taken_e = 1'b0;
  logic [1:0]       PCSrc_e;
  logic             flush_e;
  logic             illegal_br_e;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  branch_resolve_bht #(
    .XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .INIT_STATE(2'b01), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
    .valid_e(valid_e), .stall_e(stall_e), .pc_e(pc_e), .branch_e(branch_e),
    .jump_e(jump_e), .jalr_e(jalr_e), .funct3_e(funct3_e), .Zero_e(Zero_e),
    .Lt_e(Lt_e), .Ltu_e(Ltu_e), .pred_taken_e(pred_taken_e), .PCSrc_e(PCSrc_e),
    .flush_e(flush_e), .illegal_br_e(illegal_br_e), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pred_f;
    int pcsrc;
    int flush;
    int illegal;
    int brc;
    int mpc;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: counters as integers 0..3, perf counters as integers
  int model_bht [ENTRIES];
  int model_br;
  int model_mp;
  int cyc_n = 0;
  int vectors = 0;
  int miscompares = 0;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) model_bht[i] = 1;
    model_br = 0;
    model_mp = 0;
  endfunction

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  // Model evaluation for the current inputs; pushes the expectation, then advances the model
  function automatic void model_step();
    exp_t e;
    int   tk;
    bit   act;
    bit   upd;
    e.pred_f  = (model_bht[idx_of(pc_f)] >= 2) ? 1 : 0;
    e.pcsrc   = 0;
    e.flush   = 0;
    e.illegal = 0;
    e.brc     = model_br;
    e.mpc     = model_mp;
    e.cyc     = cyc_n;
    upd = 0;
    tk  = 0;
    act = reset && valid_e && !stall_e;
    case (funct3_e)
      3'd0: tk = Zero_e;
      3'd1: tk = !Zero_e;
      3'd4: tk = Lt_e;
      3'd5: tk = !Lt_e;
      3'd6: tk = Ltu_e;
      3'd7: tk = !Ltu_e;
      default: tk = 0;
    endcase
    if (act) begin
      if (jalr_e) begin
        e.pcsrc = 2; e.flush = 1;
      end else if (jump_e) begin
        e.pcsrc = 1; e.flush = 1;
      end else if (branch_e) begin
        if (funct3_e == 3'd2 || funct3_e == 3'd3) begin
          e.illegal = 1;
        end else begin
          upd = 1;
          if (tk != int'(pred_taken_e)) begin
            e.flush = 1;
            e.pcsrc = tk ? 1 : 3;
          end
        end
      end
    end
    exp_q.push_back(e);
    if (upd) begin
      int i;
      i = idx_of(pc_e);
      model_bht[i] = tk ? ((model_bht[i] + 1 > 3) ? 3 : model_bht[i] + 1)
                        : ((model_bht[i] - 1 < 0) ? 0 : model_bht[i] - 1);
      if (model_br < CNT_MAX) model_br++;
      if (e.flush && model_mp < CNT_MAX) model_mp++;
    end
    cyc_n++;
  endfunction

  task automatic drive(input bit v, input bit st, input logic [XLEN-1:0] pf,
                       input logic [XLEN-1:0] pe, input bit br, input bit jp, input bit jr,
                       input logic [2:0] f3, input bit z, input bit lt, input bit ltu,
                       input bit pte);
    @(posedge clk);
    #1;
    valid_e = v; stall_e = st; pc_f = pf; pc_e = pe; branch_e = br; jump_e = jp;
    jalr_e = jr; funct3_e = f3; Zero_e = z; Lt_e = lt; Ltu_e = ltu; pred_taken_e = pte;
    model_step();
  endtask

  task automatic idle(input logic [XLEN-1:0] pf);
    drive(0, 0, pf, 32'h0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
  endtask

  // Changes reset one time unit after a clock edge, i.e. mid-cycle
  task automatic set_reset(input bit val, input logic [XLEN-1:0] pf);
    @(posedge clk);
    #1;
    reset = val;
    valid_e = 0; branch_e = 0; jump_e = 0; jalr_e = 0; pc_f = pf;
    if (!val) model_reset();
    model_step();
  endtask

  task automatic chk(input string nm, input int act, input int exp, input int cyc);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the state update
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      chk("pred_taken_f",  int'(pred_taken_f),  e.pred_f,  e.cyc);
      chk("PCSrc_e",       int'(PCSrc_e),       e.pcsrc,   e.cyc);
      chk("flush_e",       int'(flush_e),       e.flush,   e.cyc);
      chk("illegal_br_e",  int'(illegal_br_e),  e.illegal, e.cyc);
      chk("br_count",      int'(br_count),      e.brc,     e.cyc);
      chk("mispred_count", int'(mispred_count), e.mpc,     e.cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] pe;
    logic [XLEN-1:0] pf;
    bit              pte;
    int              r;
    model_reset();
    set_reset(0, 32'h40);
    set_reset(0, 32'h40);
    set_reset(1, 32'h40);
    idle(32'h40);

    // Mispredicted taken BEQ, then prediction flips at 0x40
    drive(1, 0, 32'h40, 32'h40, 1, 0, 0, 3'd0, 1, 0, 0, 0);
    idle(32'h40);
    // Taken BLT three times -> saturate; then not-taken BGEU predicted taken
    repeat (3) drive(1, 0, 32'h40, 32'h40, 1, 0, 0, 3'd4, 0, 1, 0, 1);
    drive(1, 0, 32'h40, 32'h40, 1, 0, 0, 3'd7, 0, 0, 1, 1);
    idle(32'h40);
    // Same-cycle read/write on 0x44
    drive(1, 0, 32'h44, 32'h44, 1, 0, 0, 3'd0, 1, 0, 0, 0);
    drive(1, 0, 32'h44, 32'h44, 1, 0, 0, 3'd0, 1, 0, 0, 1);
    idle(32'h44);
    // Stall, illegal funct3, JALR over branch, JAL over branch
    drive(1, 1, 32'h48, 32'h48, 1, 0, 0, 3'd1, 0, 0, 0, 0);
    drive(1, 0, 32'h48, 32'h48, 1, 0, 0, 3'd2, 1, 0, 0, 0);
    drive(1, 0, 32'h48, 32'h48, 1, 0, 0, 3'd3, 1, 0, 0, 0);
    drive(1, 0, 32'h48, 32'h48, 1, 1, 1, 3'd0, 1, 0, 0, 0);
    drive(1, 0, 32'h48, 32'h48, 1, 1, 0, 3'd0, 1, 0, 0, 0);
    idle(32'h48);

    // Randomized traffic with occasional mid-cycle reset pulses
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        set_reset(0, 32'($urandom));
        set_reset(1, 32'($urandom));
      end
      pe  = 32'($urandom_range(0, 63)) << 2;
      pf  = ($urandom_range(0, 9) < 3) ? pe : 32'($urandom);
      pte = ($urandom_range(0, 1) == 0) ? (model_bht[idx_of(pe)] >= 2) : 1'($urandom);
      r   = $urandom_range(0, 9);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, pf, pe,
            (r >= 2) || ($urandom_range(0, 3) == 0), r == 1, r == 0,
            3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), pte);
    end

    // Counter saturation: 20 mispredicts after a clean reset
    set_reset(0, 32'h0);
    set_reset(1, 32'h0);
    for (int n = 0; n < 20; n++) begin
      drive(1, 0, 32'h0, 32'(n) << 2, 1, 0, 0, 3'd0, 1, 0, 0, 0);
    end
    idle(32'h0);
    idle(32'h0);
    // Asynchronous reset mid-cycle, held, then released mid-cycle
    set_reset(0, 32'h0);
    idle(32'h4);
    set_reset(1, 32'h8);
    idle(32'h0);
    idle(32'h4);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
